ntt_intt_host_seq: RTL and testbench
====================================

NTT_INTT_HOST_SEQ -- requirements
Module: ntt_intt_host_seq

Interface
REQ-001 Parameter: N_WORDS, default 128, 32-bit words per polynomial (256 coefficients, two per word).
REQ-002 Parameter: DONE_TIMEOUT, default 4095, maximum cycles allowed from a start pulse to done.
REQ-003 Port: clk  in  1  clock; all logic on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid / cmd_ready / cmd_op  in / out / in  1 / 1 / 1  command handshake; cmd_op 0 = forward NTT, 1 = inverse NTT.
REQ-006 Port: in_valid / in_ready / in_data  in / out / in  1 / 1 / 32  input coefficient-word stream.
REQ-007 Port: out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / 32 / 1  result stream; out_last marks word N_WORDS-1.
REQ-008 Port: busy / err  out / out  1 / 1  busy = FSM not IDLE; err = sticky timeout flag.
REQ-009 Port: load_a_f / load_a_i / start_fntt / start_intt / read_a  out  1 each  one-cycle command pulses to the NTT core.
REQ-010 Port: din / din_en  out / out  32 / 1  core write data and write strobe.
REQ-011 Port: read_en  out  1  core read request, one word per cycle asserted.
REQ-012 Port: core_dout / gnt_valid / done  in / in / in  32 / 1 / 1  core read data, its valid flag, and transform complete.

Function
REQ-013 FSM states: IDLE, LDCMD, LOAD, START, WAIT, RDCMD, READ, ERR.
REQ-014 IDLE: cmd_ready=1; on cmd_valid, latch cmd_op and go to LDCMD.
REQ-015 LDCMD, one cycle: pulse load_a_f (op 0) or load_a_i (op 1); then go to LOAD.
REQ-016 LOAD: in_ready=1; on each in_valid&in_ready, drive din=in_data and din_en=1 in the same cycle, and increment a 0..N_WORDS-1 word counter.
REQ-017 LOAD exit: after the word with counter = N_WORDS-1 is accepted, go to START; in_ready is 0 in every state except LOAD.
REQ-018 START, one cycle: pulse start_fntt (op 0) or start_intt (op 1); clear the timeout counter; go to WAIT.
REQ-019 WAIT: increment the timeout counter each cycle; done=1 -> RDCMD; counter reaching DONE_TIMEOUT with done=0 -> ERR.
REQ-020 WAIT: done and timeout expiry in the same cycle -> done wins, go to RDCMD.
REQ-021 RDCMD, one cycle: pulse read_a; reset the issue and return counters; go to READ.
REQ-022 READ: assert read_en when issued < N_WORDS and (outstanding + buffer occupancy) < 2.
REQ-023 Core response: core_dout is valid exactly one cycle after read_en, qualified by gnt_valid=1; gnt_valid=0 in that cycle is a drop and the word is re-requested (issue counter does not advance).
REQ-024 Output buffer: 2-entry FIFO; out_valid = not empty; head pops on out_valid&out_ready; no word may be lost or duplicated under any out_ready pattern.
REQ-025 out_last=1 only while the head word has index N_WORDS-1.
REQ-026 READ exit: when word N_WORDS-1 pops, go to IDLE in the next cycle.
REQ-027 ERR: err=1 (sticky), busy=1, all core strobes 0, cmd_ready=0; leave only on rst.
REQ-028 Mutual exclusion: at most one of load_a_f, load_a_i, start_fntt, start_intt, read_a may be high in any cycle.
REQ-029 Mutual exclusion: din_en and read_en are never high in the same cycle.
REQ-030 Counters are sized to ceil(log2(N_WORDS))+1 bits; the timeout counter is sized to ceil(log2(DONE_TIMEOUT+1)) bits; no counter wraps silently.

Reset
REQ-031 While rst=1, at the following clock edge: FSM -> IDLE, all counters -> 0, FIFO emptied.
REQ-032 Reset values: err=0, busy=0, out_valid=0, out_last=0, all core strobes 0, din=0, out_data=0, cmd_ready=1 from the first cycle after reset.
REQ-033 Reset mid-LOAD or mid-READ discards the partial transaction; the next command restarts from LDCMD.

Verification
REQ-034 op=0, 128 words 0..127 streamed, core model computes identity, done 50 cycles after start -> exactly one load_a_f and one start_fntt pulse, read_a pulse, out words 0..127 in order, out_last on word 127.
REQ-035 op=1, out_ready toggled 1-0-1-0 -> one load_a_i and one start_intt pulse, all 128 words delivered in order, read_en never exceeds 2 outstanding-plus-buffered.
REQ-036 done never asserted, DONE_TIMEOUT=100 -> err=1 exactly 100 cycles after START, cmd_ready held at 0 until rst.
REQ-037 gnt_valid forced 0 on the response to word 5 -> word 5 re-requested, output sequence unchanged.
REQ-038 rst asserted after 60 words loaded -> IDLE next cycle with all outputs at reset values; a full op-0 command afterwards completes correctly.
REQ-039 done coincident with timeout expiry -> RDCMD taken, err stays 0.

Source files
------------

// File: rtl/ntt_intt_host_seq.sv
// Host-side sequencer for an NTT/INTT core: takes a command, streams one
// polynomial into the core, starts the transform, waits for done (with a
// timeout), then streams the result back out through a 2-entry buffer.
module ntt_intt_host_seq #(
    parameter int N_WORDS      = 128,
    parameter int DONE_TIMEOUT = 4095   // must be >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic        load_a_f,
    output logic        load_a_i,
    output logic        start_fntt,
    output logic        start_intt,
    output logic        read_a,
    output logic [31:0] din,
    output logic        din_en,
    output logic        read_en,
    input  logic [31:0] core_dout,
    input  logic        gnt_valid,
    input  logic        done
);
    localparam int CW = $clog2(N_WORDS) + 1;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N_WORDS);
    // The start-pulse cycle counts as the first elapsed cycle, so err rises
    // exactly DONE_TIMEOUT cycles after the start pulse.
    localparam logic [TW-1:0] TMO_LIM  = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LDCMD, LOAD, START, WAIT, RDCMD, READ, ERR} state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;     // words accepted in LOAD
    logic [CW-1:0]   issue_q, issue_d;   // reads granted or still in flight
    logic [CW-1:0]   ret_q, ret_d;       // words returned into the buffer
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_q, pend_d;     // a read response is due this cycle
    logic [1:0][32:0] fifo_q, fifo_d;    // {last, data}
    logic            wp_q, wp_d, rp_q, rp_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [32:0]     head;
    logic            push, pop, drop;

    // Next-state, counters, buffer and all output strobes
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wcnt_d  = wcnt_q;
        issue_d = issue_q;
        ret_d   = ret_q;
        tmo_d   = tmo_q;
        pend_d  = 1'b0;
        fifo_d  = fifo_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        load_a_f   = 1'b0;
        load_a_i   = 1'b0;
        start_fntt = 1'b0;
        start_intt = 1'b0;
        read_a     = 1'b0;
        din        = '0;
        din_en     = 1'b0;
        read_en    = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        busy       = (state_q != IDLE);
        err        = (state_q == ERR);
        head       = fifo_q[rp_q];
        out_valid  = (cnt_q != 2'd0);
        out_data   = head[31:0];
        out_last   = out_valid & head[32];
        pop        = out_valid & out_ready;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    state_d = LDCMD;
                end
            end
            LDCMD: begin
                load_a_f = ~op_q;
                load_a_i = op_q;
                wcnt_d   = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    din    = in_data;
                    din_en = 1'b1;
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == LAST_IDX) state_d = START;
                end
            end
            START: begin
                start_fntt = ~op_q;
                start_intt = op_q;
                tmo_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (done)                  state_d = RDCMD;
                else if (tmo_d == TMO_LIM) state_d = ERR;
            end
            RDCMD: begin
                read_a  = 1'b1;
                issue_d = '0;
                ret_d   = '0;
                state_d = READ;
            end
            READ: begin
                // At most two words owed to the buffer: in flight plus stored.
                read_en = (issue_q < N_CNT) && (({1'b0, pend_q} + cnt_q) < 2'd2);
                pend_d  = read_en;
                push    = pend_q & gnt_valid;
                drop    = pend_q & ~gnt_valid;
                case ({read_en, drop})
                    2'b10:   issue_d = issue_q + CW'(1);
                    2'b01:   issue_d = issue_q - CW'(1);
                    default: issue_d = issue_q;
                endcase
                if (push) begin
                    fifo_d[wp_q] = {(ret_q == LAST_IDX), core_dout};
                    wp_d         = ~wp_q;
                    ret_d        = ret_q + CW'(1);
                end
                if (pop && out_last) state_d = IDLE;
            end
            default: ;  // ERR: held until reset, all strobes low
        endcase

        if (pop) rp_d = ~rp_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            wcnt_q  <= '0;
            issue_q <= '0;
            ret_q   <= '0;
            tmo_q   <= '0;
            pend_q  <= 1'b0;
            fifo_q  <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            fifo_q  <= fifo_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ntt_intt_host_seq.sv
// Bench for ntt_intt_host_seq: identity core model with programmable done
// delay and a one-shot read drop, plus a scoreboard on the output stream.
module tb_ntt_intt_host_seq;
    localparam int N  = 128;
    localparam int DT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic [31:0] core_dout = '0;
    logic        gnt_valid = 1'b0, done = 1'b0;
    logic        cmd_ready, in_ready, out_valid, out_last, busy, err;
    logic        load_a_f, load_a_i, start_fntt, start_intt, read_a, din_en, read_en;
    logic [31:0] out_data, din;

    always #5 clk = ~clk;

    ntt_intt_host_seq #(.N_WORDS(N), .DONE_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .load_a_f(load_a_f), .load_a_i(load_a_i), .start_fntt(start_fntt),
        .start_intt(start_intt), .read_a(read_a),
        .din(din), .din_en(din_en), .read_en(read_en),
        .core_dout(core_dout), .gnt_valid(gnt_valid), .done(done)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    // Core model: identity transform, done dly cycles after the start pulse
    // (dly < 1 means never), optional single drop of the read of word drop_idx.
    logic [31:0] cmem [N];
    int wptr = 0, rptr = 0, dcnt = 0, req5 = 0;
    int dly = -1, drop_idx = -1;
    bit run = 1'b0, dropped = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        done      <= 1'b0;
        gnt_valid <= 1'b0;
        if (rst) begin
            wptr <= 0; rptr <= 0; run <= 1'b0; dropped <= 1'b0;
        end else begin
            if (load_a_f || load_a_i) wptr <= 0;
            else if (din_en && wptr < N) begin
                cmem[wptr] <= din;
                wptr       <= wptr + 1;
            end
            if (start_fntt || start_intt) begin
                run  <= (dly > 1);
                dcnt <= 1;
                done <= (dly == 1);
            end else if (run) begin
                dcnt <= dcnt + 1;
                if (dcnt + 1 == dly) begin done <= 1'b1; run <= 1'b0; end
            end
            if (read_a) begin
                rptr <= 0; dropped <= 1'b0;
            end else if (read_en && rptr < N) begin
                core_dout <= cmem[rptr];
                if (rptr == 5) req5 <= req5 + 1;
                if (rptr == drop_idx && !dropped) dropped <= 1'b1;
                else begin gnt_valid <= 1'b1; rptr <= rptr + 1; end
            end
        end
    end

    // Output scoreboard and protocol invariants, sampled mid-cycle
    logic [31:0] exp_q[$];
    int nout = 0, base = 0;
    int n_lf = 0, n_li = 0, n_sf = 0, n_si = 0, n_ra = 0;
    int excl_bad = 0, ovf_bad = 0, pend_tb = 0, buf_tb = 0, start_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            pend_tb = 0; buf_tb = 0;
        end else begin
            if ($countones({load_a_f, load_a_i, start_fntt, start_intt, read_a}) > 1 ||
                (din_en && read_en)) excl_bad++;
            if (read_en && (pend_tb + buf_tb) >= 2) ovf_bad++;
            n_lf += int'(load_a_f); n_li += int'(load_a_i);
            n_sf += int'(start_fntt); n_si += int'(start_intt); n_ra += int'(read_a);
            if (start_fntt || start_intt) start_cyc = cyc;
            if (gnt_valid) buf_tb++;
            if (out_valid && out_ready) begin
                logic [31:0] e;
                buf_tb--;
                n_cmp += 2;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_data: got %h, required no word (queue empty)", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL out_data[%0d]: got %h, required %h", nout - base, out_data, e);
                    end
                end
                if (out_last !== (nout - base == N - 1)) begin
                    n_bad++;
                    $display("FAIL out_last[%0d]: got %b, required %b", nout - base, out_last, (nout - base == N - 1));
                end
                nout++;
            end
            pend_tb = int'(read_en);
        end
    end

    task automatic cyc1();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input bit op);
        cmd_valid = 1'b1; cmd_op = op;
        for (int i = 0; i < 50 && !cmd_ready; i++) cyc1();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL cmd_accept: cmd_ready got %b, required 1", cmd_ready);
        end
        cyc1();
        cmd_valid = 1'b0;
    endtask

    // kind 0: words 0..n-1 back to back; otherwise random words with gaps
    task automatic load_words(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            if (kind != 0 && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; cyc1(); end
            w = (kind == 0) ? 32'(i) : $urandom();
            exp_q.push_back(w);
            in_valid = 1'b1; in_data = w;
            for (int k = 0; k < 50 && !in_ready; k++) cyc1();
            if (!in_ready) begin
                n_cmp++; n_bad++; $display("FAIL in_ready: got 0 at word %0d, required 1", i);
            end
            cyc1();
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle 1-0-1-0, 2: random
    task automatic drain(input int mode);
        for (int c = 0; c < 4000 && (nout - base) < N; c++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~c[0] : 1'($urandom_range(0, 1));
            cyc1();
        end
        out_ready = 1'b1;
        n_cmp += 3;
        if (nout - base != N) begin
            n_bad++; $display("FAIL words_out: got %0d, required %0d", nout - base, N);
        end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b, required 0", busy); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic full_txn(input bit op, input int kind, input int mode, input int d, input int di);
        int s_lf, s_li, s_sf, s_si, s_ra;
        dly = d; drop_idx = di; base = nout;
        s_lf = n_lf; s_li = n_li; s_sf = n_sf; s_si = n_si; s_ra = n_ra;
        send_cmd(op);
        load_words(kind, N);
        drain(mode);
        n_cmp += 7;
        if (n_lf - s_lf != int'(!op)) begin n_bad++; $display("FAIL load_a_f_pulses: got %0d, required %0d", n_lf - s_lf, int'(!op)); end
        if (n_li - s_li != int'(op))  begin n_bad++; $display("FAIL load_a_i_pulses: got %0d, required %0d", n_li - s_li, int'(op)); end
        if (n_sf - s_sf != int'(!op)) begin n_bad++; $display("FAIL start_fntt_pulses: got %0d, required %0d", n_sf - s_sf, int'(!op)); end
        if (n_si - s_si != int'(op))  begin n_bad++; $display("FAIL start_intt_pulses: got %0d, required %0d", n_si - s_si, int'(op)); end
        if (n_ra - s_ra != 1) begin n_bad++; $display("FAIL read_a_pulses: got %0d, required 1", n_ra - s_ra); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover_words: got %0d, required 0", exp_q.size()); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL txn_err: got %b, required 0", err); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc1(); cyc1();
        n_cmp += 8;
        if ({busy, err, out_valid, out_last} !== 4'b0) begin n_bad++; $display("FAIL rst_status: busy/err/out_valid/out_last got %b, required 0000", {busy, err, out_valid, out_last}); end
        if ({load_a_f, load_a_i, start_fntt, start_intt, read_a} !== 5'b0) begin n_bad++; $display("FAIL rst_strobes: got %b, required 00000", {load_a_f, load_a_i, start_fntt, start_intt, read_a}); end
        if (din !== 32'h0) begin n_bad++; $display("FAIL rst_din: got %h, required 0", din); end
        if (din_en !== 1'b0) begin n_bad++; $display("FAIL rst_din_en: got %b, required 0", din_en); end
        if (read_en !== 1'b0) begin n_bad++; $display("FAIL rst_read_en: got %b, required 0", read_en); end
        if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        rst = 1'b0; cyc1();
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_fwd_identity();
        full_txn(1'b0, 0, 0, 50, -1);
    endtask

    task automatic test_inv_toggle();
        full_txn(1'b1, 1, 1, 50, -1);
    endtask

    task automatic test_drop();
        int r5;
        r5 = req5;
        full_txn(1'b0, 1, 2, 50, 5);
        n_cmp++;
        if (req5 - r5 != 2) begin n_bad++; $display("FAIL drop_rerequest: word 5 requested %0d times, required 2", req5 - r5); end
        drop_idx = -1;
    endtask

    task automatic test_timeout();
        int err_cyc;
        dly = -1; err_cyc = -1;
        send_cmd(1'b0);
        load_words(0, N);
        for (int c = 0; c < 400 && err !== 1'b1; c++) cyc1();
        if (err === 1'b1) err_cyc = cyc;
        n_cmp++;
        if (err_cyc - start_cyc != DT) begin n_bad++; $display("FAIL timeout_latency: err after %0d cycles, required %0d", err_cyc - start_cyc, DT); end
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if ({err, busy, cmd_ready, read_en, read_a} !== 5'b11000) begin
                n_bad++; $display("FAIL err_hold: err/busy/cmd_ready/read_en/read_a got %b, required 11000", {err, busy, cmd_ready, read_en, read_a});
            end
            cyc1();
        end
        exp_q.delete();
        test_reset();
    endtask

    task automatic test_done_at_expiry();
        full_txn(1'b0, 1, 0, DT - 1, -1);
    endtask

    task automatic test_reset_mid_load();
        send_cmd(1'b0);
        load_words(0, 60);
        exp_q.delete();
        test_reset();
        full_txn(1'b0, 0, 0, 50, -1);
    endtask

    task automatic test_back_to_back();
        full_txn(1'b1, 1, 2, 7, -1);
        full_txn(1'b0, 1, 2, 3, -1);
    endtask

    task automatic test_invariants();
        n_cmp += 2;
        if (excl_bad != 0) begin n_bad++; $display("FAIL strobe_exclusion: got %0d violating cycles, required 0", excl_bad); end
        if (ovf_bad != 0) begin n_bad++; $display("FAIL read_window: got %0d over-issue cycles, required 0", ovf_bad); end
    endtask

    initial begin
        cyc1();
        test_reset();
        test_fwd_identity();
        test_inv_toggle();
        test_drop();
        test_timeout();
        test_done_at_expiry();
        test_reset_mid_load();
        test_back_to_back();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
